// File: rtl/mono_crt_pkg.sv
// rtl/mono_crt_pkg.sv - Mac 512x342 timing defaults and width helper for the mono CRT scan-out
package mono_crt_pkg;

   localparam int MAC_ACTIVE_WIDTH   = 512;
   localparam int MAC_ACTIVE_HEIGHT  = 342;
   localparam int MAC_ACTIVE_XOFFSET = 170;
   localparam int MAC_ACTIVE_YOFFSET = 48;
   localparam int MAC_TOTAL_WIDTH    = 683;
   localparam int MAC_TOTAL_HEIGHT   = 390;
   localparam int MAC_HSYNC_WIDTH    = 294;
   localparam int MAC_VSYNC_OFFSET   = 128;
   localparam int MAC_VSYNC_LINES    = 6;
   localparam int MAC_WORD_BITS      = 16;
   localparam int MAC_ADDR_BITS      = 14;
   localparam int MAC_LINE_WORDS     = 32;

   function automatic int scan_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/crt_timing_gen.sv
// rtl/crt_timing_gen.sv - Scan counters, registered sync outputs, frame pulse and active flag
module crt_timing_gen
   import mono_crt_pkg::*;
#(
   parameter int   ACTIVE_WIDTH   = MAC_ACTIVE_WIDTH,
   parameter int   ACTIVE_HEIGHT  = MAC_ACTIVE_HEIGHT,
   parameter int   ACTIVE_XOFFSET = MAC_ACTIVE_XOFFSET,
   parameter int   ACTIVE_YOFFSET = MAC_ACTIVE_YOFFSET,
   parameter int   TOTAL_WIDTH    = MAC_TOTAL_WIDTH,
   parameter int   TOTAL_HEIGHT   = MAC_TOTAL_HEIGHT,
   parameter int   HSYNC_WIDTH    = MAC_HSYNC_WIDTH,
   parameter int   VSYNC_OFFSET   = MAC_VSYNC_OFFSET,
   parameter int   VSYNC_LINES    = MAC_VSYNC_LINES,
   parameter logic SYNC_ACTIVE    = 1'b0,
   localparam int  XW             = scan_bits(TOTAL_WIDTH),
   localparam int  YW             = scan_bits(TOTAL_HEIGHT)
) (
   input  logic          clk,
   input  logic          reset,
   output logic [XW-1:0] xscan,
   output logic [YW-1:0] yscan,
   output logic [XW-1:0] x_next,
   output logic [YW-1:0] y_next,
   output logic          pixel_active,
   output logic          hsync,
   output logic          vsync,
   output logic          frame_start
);

   int   xi, yi;
   logic hsync_on, vsync_on;

   always_comb begin
      xi = int'(xscan);
      yi = int'(yscan);
      x_next = xscan + XW'(1);
      y_next = yscan;
      if (xi == TOTAL_WIDTH - 1) begin
         x_next = '0;
         y_next = (yi == TOTAL_HEIGHT - 1) ? '0 : yscan + YW'(1);
      end
      hsync_on = xi < HSYNC_WIDTH;
      // vsync spans from (0, VSYNC_OFFSET) up to but excluding (VSYNC_LINES, VSYNC_OFFSET)
      vsync_on = ((yi < VSYNC_LINES) && ((yi != 0) || (xi >= VSYNC_OFFSET))) ||
                 ((yi == VSYNC_LINES) && (xi < VSYNC_OFFSET));
      pixel_active = (yi >= ACTIVE_YOFFSET) && (yi < ACTIVE_YOFFSET + ACTIVE_HEIGHT) &&
                     (xi >= ACTIVE_XOFFSET) && (xi < ACTIVE_XOFFSET + ACTIVE_WIDTH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xscan       <= '0;
         yscan       <= '0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         frame_start <= 1'b0;
      end else begin
         xscan       <= x_next;
         yscan       <= y_next;
         hsync       <= hsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= vsync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         frame_start <= (xi == 0) && (yi == 0);
      end
   end

endmodule

// File: rtl/mono_crt_scanout.sv
// rtl/mono_crt_scanout.sv - 1-bpp CRT scan-out: fetch scheduler, pixel shifter, write arbiter
module mono_crt_scanout
   import mono_crt_pkg::*;
#(
   parameter int   ACTIVE_WIDTH   = MAC_ACTIVE_WIDTH,
   parameter int   ACTIVE_HEIGHT  = MAC_ACTIVE_HEIGHT,
   parameter int   ACTIVE_XOFFSET = MAC_ACTIVE_XOFFSET,
   parameter int   ACTIVE_YOFFSET = MAC_ACTIVE_YOFFSET,
   parameter int   TOTAL_WIDTH    = MAC_TOTAL_WIDTH,
   parameter int   TOTAL_HEIGHT   = MAC_TOTAL_HEIGHT,
   parameter int   HSYNC_WIDTH    = MAC_HSYNC_WIDTH,
   parameter int   VSYNC_OFFSET   = MAC_VSYNC_OFFSET,
   parameter int   VSYNC_LINES    = MAC_VSYNC_LINES,
   parameter logic SYNC_ACTIVE    = 1'b0,
   parameter int   WORD_BITS      = MAC_WORD_BITS,
   parameter int   ADDR_BITS      = MAC_ADDR_BITS,
   parameter int   LINE_WORDS     = MAC_LINE_WORDS,
   localparam int  XW             = scan_bits(TOTAL_WIDTH),
   localparam int  YW             = scan_bits(TOTAL_HEIGHT)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 invert,
   input  logic                 test_pattern,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [WORD_BITS-1:0] wr_data,
   output logic                 ram_wen,
   output logic [ADDR_BITS-1:0] ram_wr_addr,
   output logic [WORD_BITS-1:0] ram_wr_data,
   output logic [ADDR_BITS-1:0] ram_rd_addr,
   input  logic [WORD_BITS-1:0] ram_rd_data,
   output logic                 video,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 frame_start
);

   localparam logic CHECKER_PHASE = ((ACTIVE_XOFFSET + ACTIVE_YOFFSET) % 2) != 0;

   logic [XW-1:0]        xscan, x_next;
   logic [YW-1:0]        yscan, y_next;
   logic                 pixel_active;
   logic                 fetch_now, fetch_next, fetch_d, pixel_bit;
   logic [WORD_BITS-1:0] shifter;

   crt_timing_gen #(
      .ACTIVE_WIDTH   (ACTIVE_WIDTH),
      .ACTIVE_HEIGHT  (ACTIVE_HEIGHT),
      .ACTIVE_XOFFSET (ACTIVE_XOFFSET),
      .ACTIVE_YOFFSET (ACTIVE_YOFFSET),
      .TOTAL_WIDTH    (TOTAL_WIDTH),
      .TOTAL_HEIGHT   (TOTAL_HEIGHT),
      .HSYNC_WIDTH    (HSYNC_WIDTH),
      .VSYNC_OFFSET   (VSYNC_OFFSET),
      .VSYNC_LINES    (VSYNC_LINES),
      .SYNC_ACTIVE    (SYNC_ACTIVE)
   ) u_timing (
      .clk          (clk),
      .reset        (reset),
      .xscan        (xscan),
      .yscan        (yscan),
      .x_next       (x_next),
      .y_next       (y_next),
      .pixel_active (pixel_active),
      .hsync        (hsync),
      .vsync        (vsync),
      .frame_start  (frame_start)
   );

   // Fetch two clocks ahead so the word lands in the shifter as its first pixel is due
   function automatic logic is_fetch(input int x, input int y);
      int dx;
      dx = x + 2 - ACTIVE_XOFFSET;
      return (y >= ACTIVE_YOFFSET) && (y < ACTIVE_YOFFSET + ACTIVE_HEIGHT) &&
             (dx >= 0) && (dx < ACTIVE_WIDTH) && ((dx % WORD_BITS) == 0);
   endfunction

   assign fetch_now   = is_fetch(int'(xscan), int'(yscan));
   assign fetch_next  = is_fetch(int'(x_next), int'(y_next));
   assign wr_ready    = ~reset & ~fetch_next;
   assign ram_rd_addr = fetch_now ?
      ADDR_BITS'((int'(yscan) - ACTIVE_YOFFSET) * LINE_WORDS +
                 (int'(xscan) + 2 - ACTIVE_XOFFSET) / WORD_BITS) : '0;
   assign pixel_bit   = test_pattern ? (xscan[0] ^ yscan[0] ^ CHECKER_PHASE)
                                     : shifter[WORD_BITS-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_d     <= 1'b0;
         shifter     <= '0;
         video       <= 1'b1;
         ram_wen     <= 1'b0;
         ram_wr_addr <= '0;
         ram_wr_data <= '0;
      end else begin
         fetch_d <= fetch_now;
         shifter <= fetch_d ? ram_rd_data : {shifter[WORD_BITS-2:0], 1'b0};
         video   <= pixel_active ? (pixel_bit ^ invert) : 1'b1;
         ram_wen <= wr_valid & wr_ready;
         if (wr_valid & wr_ready) begin
            ram_wr_addr <= wr_addr;
            ram_wr_data <= wr_data;
         end
      end
   end

endmodule

// File: tb/tb_mono_crt_scanout.sv
// tb/tb_mono_crt_scanout.sv - Self-checking bench for mono_crt_scanout on a reduced geometry
module tb_mono_crt_scanout;

   localparam int AW  = 32;
   localparam int AH  = 6;
   localparam int AXO = 10;
   localparam int AYO = 3;
   localparam int TW  = 50;
   localparam int TH  = 12;
   localparam int HSW = 6;
   localparam int VSO = 4;
   localparam int VSL = 2;
   localparam int W   = 8;
   localparam int AB  = 8;
   localparam int LW  = 8;
   localparam int FR  = TW * TH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          invert = 1'b0;
   logic          test_pattern = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AB-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic          wr_ready, ram_wen, video, hsync, vsync, frame_start;
   logic [AB-1:0] ram_wr_addr, ram_rd_addr;
   logic [W-1:0]  ram_wr_data;
   logic [W-1:0]  ram_rd_data = '0;

   mono_crt_scanout #(
      .ACTIVE_WIDTH(AW), .ACTIVE_HEIGHT(AH), .ACTIVE_XOFFSET(AXO), .ACTIVE_YOFFSET(AYO),
      .TOTAL_WIDTH(TW), .TOTAL_HEIGHT(TH), .HSYNC_WIDTH(HSW), .VSYNC_OFFSET(VSO),
      .VSYNC_LINES(VSL), .SYNC_ACTIVE(1'b0), .WORD_BITS(W), .ADDR_BITS(AB), .LINE_WORDS(LW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .invert       (invert),
      .test_pattern (test_pattern),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .ram_wen      (ram_wen),
      .ram_wr_addr  (ram_wr_addr),
      .ram_wr_data  (ram_wr_data),
      .ram_rd_addr  (ram_rd_addr),
      .ram_rd_data  (ram_rd_data),
      .video        (video),
      .hsync        (hsync),
      .vsync        (vsync),
      .frame_start  (frame_start)
   );

   always #5 clk = ~clk;

   // Framebuffer RAM with one clock of read latency
   logic [W-1:0] init_mem [256];
   logic [W-1:0] mem [256];
   logic         load = 1'b1;

   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
      end else if (ram_wen) begin
         mem[ram_wr_addr] <= ram_wr_data;
      end
      ram_rd_data <= mem[ram_rd_addr];
   end

   typedef struct {
      int           t;
      int           a;
      logic [W-1:0] v;
   } wr_rec_t;

   wr_rec_t      wq[$];
   int           n_assert = 0;
   int           n_fail = 0;
   int           p = 0;
   int           g = 0;
   int           low_cnt = 0;
   logic         acc_prev = 1'b0;
   logic [AB-1:0] acc_addr = '0;
   logic [W-1:0] acc_data = '0;
   logic         inv_prev = 1'b0;
   logic         tp_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int px(input int pos); return pos % TW; endfunction
   function automatic int py(input int pos); return (pos / TW) % TH; endfunction

   function automatic logic fetch_at(input int pos);
      int y, dx;
      y  = py(pos) - AYO;
      dx = px(pos) + 2 - AXO;
      return (y >= 0) && (y < AH) && (dx >= 0) && (dx < AW) && ((dx % W) == 0);
   endfunction

   // Word contents as they stood at time f: the latest write accepted strictly before f
   function automatic logic [W-1:0] seen(input int a, input int f);
      logic [W-1:0] v;
      v = init_mem[a];
      foreach (wq[i]) if (wq[i].a == a && wq[i].t < f) v = wq[i].v;
      return v;
   endfunction

   function automatic logic exp_video(input int q, input int gq, input logic inv, input logic tp);
      int           x, y;
      logic [W-1:0] wd;
      logic         pix;
      x = px(q) - AXO;
      y = py(q) - AYO;
      if (x < 0 || x >= AW || y < 0 || y >= AH) return 1'b1;
      if (tp) begin
         pix = ((x ^ y) & 1) != 0;
      end else begin
         wd  = seen(y * LW + x / W, gq - (x % W) - 2);
         pix = wd[W - 1 - (x % W)];
      end
      return pix ^ inv;
   endfunction

   function automatic logic exp_vsync(input int q);
      int lin;
      lin = py(q) * TW + px(q);
      return !((lin >= VSO) && (lin < VSL * TW + VSO));
   endfunction

   task automatic tick();
      int q;
      @(negedge clk);
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, !fetch_at(p + 1)});
      if (!wr_ready) low_cnt++;
      if (fetch_at(p)) begin
         chk("rd_addr", {24'd0, ram_rd_addr}, (py(p) - AYO) * LW + (px(p) + 2 - AXO) / W);
         chk("wen_on_fetch", {31'd0, ram_wen}, 0);
      end
      if (p == 0) begin
         chk("hsync_rel", {31'd0, hsync}, 1);
         chk("vsync_rel", {31'd0, vsync}, 1);
         chk("video_rel", {31'd0, video}, 1);
         chk("fs_rel", {31'd0, frame_start}, 0);
      end else begin
         q = p - 1;
         chk("hsync", {31'd0, hsync}, (px(q) < HSW) ? 0 : 1);
         chk("vsync", {31'd0, vsync}, {31'd0, exp_vsync(q)});
         chk("frame_start", {31'd0, frame_start}, ((q % FR) == 0) ? 1 : 0);
         chk("video", {31'd0, video}, {31'd0, exp_video(q, g - 1, inv_prev, tp_prev)});
      end
      chk("ram_wen", {31'd0, ram_wen}, {31'd0, acc_prev});
      if (acc_prev) begin
         chk("wr_addr_out", {24'd0, ram_wr_addr}, {24'd0, acc_addr});
         chk("wr_data_out", {24'd0, ram_wr_data}, {24'd0, acc_data});
      end
      acc_prev = wr_valid && wr_ready;
      if (acc_prev) begin
         acc_addr = wr_addr;
         acc_data = wr_data;
         wq.push_back('{t: g, a: int'(wr_addr), v: wr_data});
      end
      inv_prev = invert;
      tp_prev  = test_pattern;
      @(posedge clk);
      #1;
      p++;
      g++;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hsync"}, {31'd0, hsync}, 1);
      chk({tag, "_vsync"}, {31'd0, vsync}, 1);
      chk({tag, "_video"}, {31'd0, video}, 1);
      chk({tag, "_wen"}, {31'd0, ram_wen}, 0);
      chk({tag, "_ready"}, {31'd0, wr_ready}, 0);
      chk({tag, "_fs"}, {31'd0, frame_start}, 0);
   endtask

   initial begin
      int guard;
      int target;
      for (int i = 0; i < 256; i++) init_mem[i] = W'($urandom);
      init_mem[0]      = 8'h81;
      init_mem[LW + 1] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
      reset = 1'b0;
      load  = 1'b0;
      p = 0;

      // Idle frames: sync timing and RAM image, word 0 = 8'h81
      repeat (2 * FR) tick();

      // Continuous write pressure for one aligned frame
      while ((p % FR) != 0) tick();
      low_cnt = 0;
      repeat (FR) begin
         wr_valid = 1'b1;
         wr_addr  = AB'($urandom_range(0, AH * LW - 1));
         wr_data  = W'($urandom);
         tick();
      end
      wr_valid = 1'b0;
      chk("ready_low_per_frame", low_cnt, AH * AW / W);

      // Write hitting the word-1 fetch of active line 1 in that very cycle
      wr_valid = 1'b1;
      wr_addr  = AB'(LW + 1);
      wr_data  = 8'h3C;
      tick();
      wr_valid = 1'b0;
      target = (AYO + 1) * TW + AXO + W - 2;
      guard  = 0;
      while ((p % FR) != target && guard < 2 * FR) begin
         tick();
         guard++;
      end
      chk("t4_reach", p % FR, target);
      chk("t4_ready", {31'd0, wr_ready}, 1);
      wr_valid = 1'b1;
      wr_data  = 8'hFF;
      tick();
      wr_valid = 1'b0;
      repeat (2 * FR) tick();

      // Per-pixel random invert / test-pattern with sparse writes
      repeat (FR) begin
         invert       = ($urandom & 1) != 0;
         test_pattern = ($urandom & 1) != 0;
         wr_valid     = $urandom_range(0, 3) == 0;
         wr_addr      = AB'($urandom_range(0, AH * LW - 1));
         wr_data      = W'($urandom);
         tick();
      end
      wr_valid     = 1'b0;
      invert       = 1'b1;
      test_pattern = 1'b1;
      repeat (FR) tick();

      // Mid-line asynchronous reset
      invert       = 1'b0;
      test_pattern = 1'b0;
      repeat (5) tick();
      guard = 0;
      while (!(px(p) == 30 && py(p) == AYO + 2) && guard < 2 * FR) begin
         tick();
         guard++;
      end
      chk("mid_reach", px(p), 30);
      reset = 1'b1;
      #2;
      chk_reset_state("async");
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      p        = 0;
      acc_prev = 1'b0;
      repeat (FR + 10) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
